// File: rtl/music_player_pkg.sv
// Shared widths, ROM contents and state types for the music player.
// SONG_ROM entries are {note[5:0], dur[5:0]}; dur 0 ends a song, note 0 is a rest.
package music_player_pkg;

  localparam int unsigned NOTE_W    = 6;
  localparam int unsigned DUR_W     = 6;
  localparam int unsigned PHASE_W   = 20;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned VOL_W     = 3;
  localparam int unsigned KEY_W     = 4;
  localparam int unsigned NUM_SONGS = 4;
  localparam int unsigned SONG_LEN  = 32;
  localparam int unsigned SONG_W    = $clog2(NUM_SONGS);
  localparam int unsigned ADDR_W    = $clog2(SONG_LEN);
  localparam int unsigned ENTRY_W   = NOTE_W + DUR_W;
  localparam int unsigned ROM_DEPTH = NUM_SONGS * SONG_LEN;
  localparam int unsigned NUM_NOTES = 2 ** NOTE_W;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_entry_t;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_PLAYING = 1'b1
  } play_state_e;

  localparam logic [ENTRY_W-1:0] SONG_ROM [ROM_DEPTH] = '{
    0:  {6'd49, 6'd2},
    1:  {6'd53, 6'd1},
    2:  {6'd56, 6'd1},
    3:  {6'd0,  6'd1},
    4:  {6'd61, 6'd2},
    32: {6'd49, 6'd4},
    33: {6'd52, 6'd2},
    34: {6'd0,  6'd1},
    35: {6'd57, 6'd1},
    64: {6'd40, 6'd1},
    65: {6'd44, 6'd1},
    66: {6'd47, 6'd1},
    67: {6'd52, 6'd2},
    96: {6'd1,  6'd1},
    97: {6'd63, 6'd1},
    98: {6'd25, 6'd1},
    99: {6'd37, 6'd1},
    default: '0
  };

  // Phase increment per 48 kHz frame for each piano key, 2^20 = one period.
  localparam logic [PHASE_W-1:0] STEP_ROM [NUM_NOTES] = '{
    20'd0,     20'd601,   20'd636,   20'd674,   20'd714,   20'd757,   20'd802,   20'd850,
    20'd900,   20'd954,   20'd1010,  20'd1070,  20'd1134,  20'd1201,  20'd1273,  20'd1349,
    20'd1429,  20'd1514,  20'd1604,  20'd1699,  20'd1800,  20'd1907,  20'd2021,  20'd2141,
    20'd2268,  20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,  20'd3398,
    20'd3600,  20'd3815,  20'd4041,  20'd4282,  20'd4536,  20'd4806,  20'd5092,  20'd5395,
    20'd5715,  20'd6055,  20'd6415,  20'd6797,  20'd7201,  20'd7629,  20'd8083,  20'd8563,
    20'd9072,  20'd9612,  20'd10184, 20'd10789, 20'd11431, 20'd12110, 20'd12830, 20'd13593,
    20'd14402, 20'd15258, 20'd16165, 20'd17127, 20'd18145, 20'd19224, 20'd20367, 20'd21578
  };

endpackage

// File: rtl/music_player_if.sv
// Front-panel inputs and codec sample output of the music player.
interface music_player_if;
  import music_player_pkg::*;

  logic                play_button;
  logic                next_button;
  logic                new_frame;
  logic [VOL_W-1:0]    sw_value;
  logic [KEY_W-1:0]    keypad_value;
  logic                color_changing;
  logic                new_sample_generated;
  logic [SAMPLE_W-1:0] sample_out;

  modport master (
    output play_button, next_button, new_frame, sw_value, keypad_value, color_changing,
    input  new_sample_generated, sample_out
  );

  modport slave (
    input  play_button, next_button, new_frame, sw_value, keypad_value, color_changing,
    output new_sample_generated, sample_out
  );

endinterface

// File: rtl/music_player_note_synth.sv
// Phase accumulator plus triangle/square shaping and volume shift.
// The sample is formed from the phase before this frame's increment.
module note_synth
  import music_player_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_i,
  input  logic                adv_i,
  input  logic                wrap_i,
  input  logic [NOTE_W-1:0]   note_i,
  input  logic                tri_i,
  input  logic [VOL_W-1:0]    vol_i,
  input  logic                mute_i,
  output logic [SAMPLE_W-1:0] sample_c_o
);

  logic [PHASE_W-1:0]         phase_q;
  logic [PHASE_W-1:0]         phase_d;
  logic [PHASE_W-1:0]         phase_a_c;
  logic [SAMPLE_W-2:0]        u_c;
  logic signed [SAMPLE_W-1:0] wave_c;
  logic [VOL_W-1:0]           shift_c;

  always_comb begin
    phase_a_c = clr_i ? '0 : phase_q;
    phase_d   = phase_a_c;
    if (wrap_i) begin
      phase_d = '0;
    end else if (adv_i) begin
      phase_d = phase_a_c + STEP_ROM[note_i];
    end

    u_c = phase_a_c[PHASE_W-2:4];
    if (tri_i) begin
      wave_c = phase_a_c[PHASE_W-1] ? signed'(SAMPLE_W'(16383) - {1'b0, u_c})
                                    : signed'({1'b0, u_c} - SAMPLE_W'(16384));
    end else begin
      wave_c = phase_a_c[PHASE_W-1] ? signed'(SAMPLE_W'(16'hC001)) : signed'(SAMPLE_W'(16383));
    end

    shift_c    = VOL_W'(7) - vol_i;
    sample_c_o = mute_i ? '0 : SAMPLE_W'(wave_c >>> shift_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/music_player_core.sv
// Song player: control FSM, song/note sequencing and the registered codec sample.
// Button/keypad actions are applied first; a same-cycle frame sees the post-action state.
module music_player_core
  import music_player_pkg::*;
#(
  parameter int unsigned BEAT_FRAMES = 16
) (
  input  logic           clk,
  input  logic           reset,
  music_player_if.slave  io
);

  localparam int unsigned FRAME_W = (BEAT_FRAMES > 1) ? $clog2(BEAT_FRAMES) : 1;

  play_state_e         state_q, state_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [DUR_W-1:0]    beat_q, beat_d;
  logic [KEY_W-1:0]    key_prev_q, key_prev_d;
  logic                strobe_q, strobe_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;

  logic                key_load_c;
  logic                rewind_c;
  logic                playing_a_c;
  logic                step_en_c;
  logic                note_wrap_c;
  logic                mute_c;
  rom_entry_t          entry_c;
  logic [SAMPLE_W-1:0] synth_sample_c;

  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    addr_d      = addr_q;
    frame_d     = frame_q;
    beat_d      = beat_q;
    key_prev_d  = io.keypad_value;
    strobe_d    = io.new_frame;
    sample_d    = sample_q;
    rewind_c    = 1'b0;
    step_en_c   = 1'b0;
    note_wrap_c = 1'b0;

    key_load_c = (io.keypad_value != key_prev_q) && (io.keypad_value < KEY_W'(NUM_SONGS));
    if (key_load_c) begin
      song_d   = io.keypad_value[SONG_W-1:0];
      rewind_c = 1'b1;
      state_d  = ST_PLAYING;
    end else if (io.next_button) begin
      song_d   = song_q + SONG_W'(1);
      rewind_c = 1'b1;
      state_d  = ST_PLAYING;
    end else if (io.play_button) begin
      state_d = (state_q == ST_PLAYING) ? ST_STOPPED : ST_PLAYING;
    end

    if (rewind_c) begin
      addr_d  = '0;
      frame_d = '0;
      beat_d  = '0;
    end

    playing_a_c = (state_d == ST_PLAYING);
    entry_c     = rom_entry_t'(SONG_ROM[{song_d, addr_d}]);
    mute_c      = !playing_a_c || (entry_c.dur == '0) || (entry_c.note == '0);

    // Frame/beat counting; the last frame of the note moves to the next entry.
    if (io.new_frame && playing_a_c) begin
      if (entry_c.dur == '0) begin
        state_d = ST_STOPPED;
        addr_d  = '0;
      end else begin
        step_en_c = 1'b1;
        if (frame_d == FRAME_W'(BEAT_FRAMES - 1)) begin
          frame_d = '0;
          if (beat_d == entry_c.dur - DUR_W'(1)) begin
            beat_d      = '0;
            addr_d      = addr_d + ADDR_W'(1);
            note_wrap_c = 1'b1;
          end else begin
            beat_d = beat_d + DUR_W'(1);
          end
        end else begin
          frame_d = frame_d + FRAME_W'(1);
        end
      end
    end

    if (io.new_frame) begin
      sample_d = synth_sample_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_STOPPED;
      song_q     <= '0;
      addr_q     <= '0;
      frame_q    <= '0;
      beat_q     <= '0;
      key_prev_q <= '0;
      strobe_q   <= 1'b0;
      sample_q   <= '0;
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      addr_q     <= addr_d;
      frame_q    <= frame_d;
      beat_q     <= beat_d;
      key_prev_q <= key_prev_d;
      strobe_q   <= strobe_d;
      sample_q   <= sample_d;
    end
  end

  note_synth u_note_synth (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (rewind_c),
    .adv_i      (step_en_c),
    .wrap_i     (note_wrap_c),
    .note_i     (entry_c.note),
    .tri_i      (io.color_changing),
    .vol_i      (io.sw_value),
    .mute_i     (mute_c),
    .sample_c_o (synth_sample_c)
  );

  assign io.new_sample_generated = strobe_q;
  assign io.sample_out           = sample_q;

endmodule

// File: tb/tb_music_player_core.sv
// Directed and random stimulus for music_player_core against a frame-level player model.
module tb_music_player_core;
  import music_player_pkg::*;

  localparam int unsigned BF = 16;

  logic clk;
  logic reset;

  music_player_if io ();

  music_player_core #(.BEAT_FRAMES(BF)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Model: one frame counter per note instead of beat/frame pairs.
  bit m_play;
  bit m_strobe;
  int m_song, m_addr, m_fcnt, m_phase, m_kprev, m_sample;
  int step_tab [64];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int wave_val(input int ph, input bit tri_sel, input int sw);
    int u;
    int w;
    u = (ph >> 4) & 32767;
    if (tri_sel) w = (ph < 524288) ? (u - 16384) : (16383 - u);
    else         w = (ph < 524288) ? 16383 : -16383;
    return w >>> (7 - sw);
  endfunction

  task automatic model_step();
    logic [ENTRY_W-1:0] ent;
    int note;
    int dur;
    int kp;
    if (reset) begin
      m_play = 0; m_song = 0; m_addr = 0; m_fcnt = 0; m_phase = 0;
      m_kprev = 0; m_sample = 0; m_strobe = 0;
      return;
    end
    kp = int'(io.keypad_value);
    if (kp != m_kprev && kp < 4) begin
      m_song = kp; m_addr = 0; m_fcnt = 0; m_phase = 0; m_play = 1;
    end else if (io.next_button) begin
      m_song = (m_song + 1) % 4; m_addr = 0; m_fcnt = 0; m_phase = 0; m_play = 1;
    end else if (io.play_button) begin
      m_play = !m_play;
    end
    m_kprev  = kp;
    m_strobe = io.new_frame;
    if (io.new_frame) begin
      ent  = SONG_ROM[m_song * 32 + m_addr];
      note = int'(ent[11:6]);
      dur  = int'(ent[5:0]);
      m_sample = (m_play && dur != 0 && note != 0)
                 ? wave_val(m_phase, io.color_changing, int'(io.sw_value)) : 0;
      if (m_play) begin
        if (dur == 0) begin
          m_play = 0;
          m_addr = 0;
        end else begin
          m_phase = (m_phase + step_tab[note]) % (1 << 20);
          m_fcnt++;
          if (m_fcnt == dur * int'(BF)) begin
            m_addr  = (m_addr + 1) % 32;
            m_fcnt  = 0;
            m_phase = 0;
          end
        end
      end
    end
  endtask

  task automatic cycle(input bit pb, input bit nb, input bit nf);
    io.play_button = pb;
    io.next_button = nb;
    io.new_frame   = nf;
    model_step();
    @(posedge clk);
    #1;
    check_eq("strobe", int'(io.new_sample_generated), int'(m_strobe));
    check_eq("sample", int'($signed(io.sample_out)), m_sample);
    io.play_button = 1'b0;
    io.next_button = 1'b0;
    io.new_frame   = 1'b0;
  endtask

  task automatic frames(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    real f;
    step_tab[0] = 0;
    for (int n = 1; n < 64; n++) begin
      f = 440.0 * (2.0 ** (real'(n - 49) / 12.0)) * 1048576.0 / 48000.0;
      step_tab[n] = $rtoi(f + 0.5);
    end

    reset = 1'b1;
    io.play_button = 1'b0; io.next_button = 1'b0; io.new_frame = 1'b0;
    io.keypad_value = 4'd0; io.sw_value = 3'd0; io.color_changing = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("reset_strobe", int'(io.new_sample_generated), 0);
    reset = 1'b0;

    frames(4, 4);
    check_eq("idle_sample", int'($signed(io.sample_out)), 0);

    // Keypad start on song 1: triangle, volume >>>2.
    io.sw_value = 3'd5; io.color_changing = 1'b1; io.keypad_value = 4'd1;
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("first_sample", int'($signed(io.sample_out)), -4096);
    for (int i = 0; i < 63; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("note_boundary", int'($signed(io.sample_out)), -4096);

    // Pause mid-note, hold, then resume.
    frames(5, 1);
    cycle(1'b1, 1'b0, 1'b1);
    check_eq("paused_zero", int'($signed(io.sample_out)), 0);
    frames(3, 1);
    cycle(1'b1, 1'b0, 1'b0);
    frames(5, 1);

    io.keypad_value = 4'd9;
    frames(3, 1);

    // Next from song 1 through 3 and wrap to 0.
    cycle(1'b0, 1'b1, 1'b0);
    frames(2, 1);
    cycle(1'b0, 1'b1, 1'b1);
    frames(2, 1);
    cycle(1'b0, 1'b1, 1'b1);
    check_eq("next_wrap", int'($signed(io.sample_out)), -4096);
    frames(4, 1);

    // Keypad beats next in the same cycle; then play song 2 to its end.
    io.keypad_value = 4'd2;
    cycle(1'b0, 1'b1, 1'b1);
    frames(90, 1);
    check_eq("end_of_song", int'($signed(io.sample_out)), 0);

    io.color_changing = 1'b0; io.sw_value = 3'd7; io.keypad_value = 4'd3;
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("square_max", int'($signed(io.sample_out)), 16383);
    io.sw_value = 3'd0; io.keypad_value = 4'd0;
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("square_min", int'($signed(io.sample_out)), 127);
    frames(40, 0);

    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("reset_override", int'(io.new_sample_generated), 0);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) io.keypad_value = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) io.sw_value = 3'($urandom);
      if ($urandom_range(0, 99) == 0) io.color_changing = 1'($urandom);
      reset = ($urandom_range(0, 799) == 0);
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 89) == 0, $urandom_range(0, 2) == 0);
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
